// File: rtl/hazard_pkg.sv
// Shared types and default widths for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned COUNT_WIDTH    = 32;
    localparam int unsigned MEM_TIMEOUT    = 64;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
    } stall_t;

    typedef struct packed {
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } flush_t;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use, mul/div occupancy,
// data-memory wait and taken-branch flush, plus stall statistics and memory timeout.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned RegAddrWidth = REG_ADDR_WIDTH,
    parameter int unsigned CountWidth   = COUNT_WIDTH,
    parameter int unsigned MemTimeout   = MEM_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [RegAddrWidth-1:0] ID_RS1,
    input  logic [RegAddrWidth-1:0] ID_RS2,
    input  logic                    ID_RS1_used,
    input  logic                    ID_RS2_used,
    input  logic [RegAddrWidth-1:0] EX_RD,
    input  logic                    EX_Reg_File_EN,
    input  logic                    EX_Mem_Read_EN,
    input  logic                    EX_Is_MulDiv,
    input  logic                    EX_Branch_Taken,
    input  logic                    MulDiv_done,
    input  logic                    MEM_Access_EN,
    input  logic                    DMem_ack,
    output logic                    MulDiv_start,
    output logic                    PC_stall,
    output logic                    IF_ID_stall,
    output logic                    ID_EX_stall,
    output logic                    EX_MEM_stall,
    output logic                    IF_ID_flush,
    output logic                    ID_EX_flush,
    output logic                    EX_MEM_flush,
    output logic                    MEM_WB_flush,
    output logic [CountWidth-1:0]   Stall_count,
    output logic                    Mem_Timeout_err
);

    localparam int unsigned WaitWidth = $clog2(MemTimeout + 1);

    md_state_t md_state_q;
    logic      md_done_held_q;
    logic      mem_timeout_err_q;

    logic [WaitWidth-1:0] mem_wait_cnt;

    logic   mem_stall;
    logic   load_use;
    logic   md_wait;
    logic   md_done_any;
    stall_t stall;
    flush_t flush;

    assign mem_stall   = MEM_Access_EN & ~DMem_ack;
    assign md_done_any = MulDiv_done | md_done_held_q;

    assign load_use = EX_Mem_Read_EN & EX_Reg_File_EN & (EX_RD != '0) &
                      ((ID_RS1_used & (ID_RS1 == EX_RD)) |
                       (ID_RS2_used & (ID_RS2 == EX_RD)));

    assign md_wait = ((md_state_q == MD_IDLE) & EX_Is_MulDiv) |
                     ((md_state_q == MD_BUSY) & ~md_done_any);

    // Start is suppressed during reset so an abandoned op is never relaunched early.
    assign MulDiv_start = (md_state_q == MD_IDLE) & EX_Is_MulDiv & ~mem_stall & ~reset;

    always_comb begin
        stall = '0;
        flush = '0;
        if (mem_stall) begin
            stall        = '1;
            flush.mem_wb = 1'b1;
        end else if (md_wait) begin
            stall.pc     = 1'b1;
            stall.if_id  = 1'b1;
            stall.id_ex  = 1'b1;
            flush.ex_mem = 1'b1;
        end else if (EX_Branch_Taken) begin
            flush.if_id  = 1'b1;
            flush.id_ex  = 1'b1;
        end else if (load_use) begin
            stall.pc     = 1'b1;
            stall.if_id  = 1'b1;
            flush.id_ex  = 1'b1;
        end
    end

    assign PC_stall     = stall.pc;
    assign IF_ID_stall  = stall.if_id;
    assign ID_EX_stall  = stall.id_ex;
    assign EX_MEM_stall = stall.ex_mem;
    assign IF_ID_flush  = flush.if_id;
    assign ID_EX_flush  = flush.id_ex;
    assign EX_MEM_flush = flush.ex_mem;
    assign MEM_WB_flush = flush.mem_wb;

    // A done pulse landing under a memory stall is held until EX_MEM can capture it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_state_q     <= MD_IDLE;
            md_done_held_q <= 1'b0;
        end else begin
            case (md_state_q)
                MD_IDLE: begin
                    md_done_held_q <= 1'b0;
                    if (EX_Is_MulDiv && !mem_stall) begin
                        md_state_q <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    if (md_done_any && !mem_stall) begin
                        md_state_q     <= MD_IDLE;
                        md_done_held_q <= 1'b0;
                    end else if (MulDiv_done && mem_stall) begin
                        md_done_held_q <= 1'b1;
                    end
                end
                default: begin
                    md_state_q     <= MD_IDLE;
                    md_done_held_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_timeout_err_q <= 1'b0;
        end else if (mem_stall && (mem_wait_cnt >= WaitWidth'(MemTimeout - 1))) begin
            mem_timeout_err_q <= 1'b1;
        end
    end

    assign Mem_Timeout_err = mem_timeout_err_q;

    sat_counter #(
        .Width(WaitWidth)
    ) u_mem_wait_cnt (
        .clk    (clk),
        .rst    (reset),
        .clr_i  (~mem_stall),
        .inc_i  (mem_stall),
        .count_o(mem_wait_cnt)
    );

    sat_counter #(
        .Width(CountWidth)
    ) u_stall_cnt (
        .clk    (clk),
        .rst    (reset),
        .clr_i  (1'b0),
        .inc_i  (stall.pc),
        .count_o(Stall_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: single-cycle vector table plus
// hand-written mul/div, overlap, timeout and reset sequences.
module tb_hazard_control_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  ID_RS1, ID_RS2, EX_RD;
    logic        ID_RS1_used, ID_RS2_used;
    logic        EX_Reg_File_EN, EX_Mem_Read_EN, EX_Is_MulDiv, EX_Branch_Taken;
    logic        MulDiv_done, MEM_Access_EN, DMem_ack;
    logic        MulDiv_start, PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall;
    logic        IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush;
    logic [31:0] Stall_count;
    logic        Mem_Timeout_err;

    int checks = 0;
    int errors = 0;

    hazard_control_unit #(
        .RegAddrWidth(5),
        .CountWidth  (32),
        .MemTimeout  (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ID_RS1         (ID_RS1),
        .ID_RS2         (ID_RS2),
        .ID_RS1_used    (ID_RS1_used),
        .ID_RS2_used    (ID_RS2_used),
        .EX_RD          (EX_RD),
        .EX_Reg_File_EN (EX_Reg_File_EN),
        .EX_Mem_Read_EN (EX_Mem_Read_EN),
        .EX_Is_MulDiv   (EX_Is_MulDiv),
        .EX_Branch_Taken(EX_Branch_Taken),
        .MulDiv_done    (MulDiv_done),
        .MEM_Access_EN  (MEM_Access_EN),
        .DMem_ack       (DMem_ack),
        .MulDiv_start   (MulDiv_start),
        .PC_stall       (PC_stall),
        .IF_ID_stall    (IF_ID_stall),
        .ID_EX_stall    (ID_EX_stall),
        .EX_MEM_stall   (EX_MEM_stall),
        .IF_ID_flush    (IF_ID_flush),
        .ID_EX_flush    (ID_EX_flush),
        .EX_MEM_flush   (EX_MEM_flush),
        .MEM_WB_flush   (MEM_WB_flush),
        .Stall_count    (Stall_count),
        .Mem_Timeout_err(Mem_Timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {start, pc_s, ifid_s, idex_s, exmem_s, ifid_f, idex_f, exmem_f, memwb_f}
    logic [8:0] outv;
    assign outv = {MulDiv_start, PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
                   IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush};

    localparam logic [8:0] NONE = 9'b000000000;
    localparam logic [8:0] LU   = 9'b011000100;
    localparam logic [8:0] BR   = 9'b000001100;
    localparam logic [8:0] MEMP = 9'b011110001;
    localparam logic [8:0] MDS  = 9'b111100010;
    localparam logic [8:0] MDW  = 9'b011100010;

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, exrd;
        logic       u1, u2, we, ld, md, br, done, memen, ack;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic zero_inputs();
        ID_RS1 = '0; ID_RS2 = '0; EX_RD = '0;
        ID_RS1_used = 0; ID_RS2_used = 0;
        EX_Reg_File_EN = 0; EX_Mem_Read_EN = 0; EX_Is_MulDiv = 0; EX_Branch_Taken = 0;
        MulDiv_done = 0; MEM_Access_EN = 0; DMem_ack = 0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        zero_inputs();
        #1 reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        ID_RS1 = v.rs1; ID_RS2 = v.rs2; EX_RD = v.exrd;
        ID_RS1_used = v.u1; ID_RS2_used = v.u2;
        EX_Reg_File_EN = v.we; EX_Mem_Read_EN = v.ld; EX_Is_MulDiv = v.md;
        EX_Branch_Taken = v.br; MulDiv_done = v.done;
        MEM_Access_EN = v.memen; DMem_ack = v.ack;
    endtask

    initial begin
        //          name              rs1 rs2 exrd u1 u2 we ld md br dn me ak exp
        vecs[0]  = '{"idle",          0,  0,  0,   0, 0, 0, 0, 0, 0, 0, 0, 0, NONE};
        vecs[1]  = '{"lu_rs2",        1,  5,  5,   1, 1, 1, 1, 0, 0, 0, 0, 0, LU};
        vecs[2]  = '{"lu_rs1",        7,  3,  7,   1, 0, 1, 1, 0, 0, 0, 0, 0, LU};
        vecs[3]  = '{"lu_rd0",        1,  0,  0,   1, 1, 1, 1, 0, 0, 0, 0, 0, NONE};
        vecs[4]  = '{"lu_unused",     1,  5,  5,   1, 0, 1, 1, 0, 0, 0, 0, 0, NONE};
        vecs[5]  = '{"lu_nowrite",    5,  2,  5,   1, 1, 0, 1, 0, 0, 0, 0, 0, NONE};
        vecs[6]  = '{"lu_notload",    5,  2,  5,   1, 1, 1, 0, 0, 0, 0, 0, 0, NONE};
        vecs[7]  = '{"br_over_lu",    1,  5,  5,   1, 1, 1, 1, 0, 1, 0, 0, 0, BR};
        vecs[8]  = '{"br_only",       0,  0,  0,   0, 0, 0, 0, 0, 1, 0, 0, 0, BR};
        vecs[9]  = '{"mem_stall",     0,  0,  0,   0, 0, 0, 0, 0, 0, 0, 1, 0, MEMP};
        vecs[10] = '{"mem_acked",     0,  0,  0,   0, 0, 0, 0, 0, 0, 0, 1, 1, NONE};
        vecs[11] = '{"mem_over_all",  1,  5,  5,   1, 1, 1, 1, 1, 1, 0, 1, 0, MEMP};
        vecs[12] = '{"md_over_br",    1,  5,  5,   1, 1, 1, 1, 1, 1, 0, 0, 0, MDS};
        vecs[13] = '{"done_in_idle",  0,  0,  0,   0, 0, 0, 0, 0, 0, 1, 0, 0, NONE};

        reset = 1'b1;
        zero_inputs();
        @(negedge clk);
        chk("reset_outputs", 32'(outv), 32'(NONE));
        chk("reset_stall_count", Stall_count, 0);
        chk("reset_timeout", 32'(Mem_Timeout_err), 0);
        next_cycle();
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i]);
            @(negedge clk);
            chk({"vec_", vecs[i].name}, 32'(outv), 32'(vecs[i].exp));
            next_cycle();
            chk({"cnt_", vecs[i].name}, Stall_count, 32'(vecs[i].exp[7]));
            pulse_reset();
        end

        // Mul/div with done 4 cycles after start.
        EX_Is_MulDiv = 1'b1;
        @(negedge clk);
        chk("md_start", 32'(outv), 32'(MDS));
        for (int c = 1; c < 4; c++) begin
            next_cycle();
            @(negedge clk);
            chk("md_wait", 32'(outv), 32'(MDW));
        end
        next_cycle();
        MulDiv_done = 1'b1;
        @(negedge clk);
        chk("md_release", 32'(outv), 32'(NONE));
        next_cycle();
        EX_Is_MulDiv = 1'b0;
        MulDiv_done = 1'b0;
        chk("md_stall_count", Stall_count, 4);
        @(negedge clk);
        chk("md_after", 32'(outv), 32'(NONE));
        next_cycle();
        pulse_reset();

        // Memory stall overlapping a mul/div completion.
        EX_Is_MulDiv = 1'b1;
        @(negedge clk);
        chk("ov_start", 32'(outv), 32'(MDS));
        next_cycle();
        MEM_Access_EN = 1'b1;
        @(negedge clk);
        chk("ov_mem1", 32'(outv), 32'(MEMP));
        next_cycle();
        MulDiv_done = 1'b1;
        @(negedge clk);
        chk("ov_mem2_done", 32'(outv), 32'(MEMP));
        next_cycle();
        MulDiv_done = 1'b0;
        @(negedge clk);
        chk("ov_mem3_held", 32'(outv), 32'(MEMP));
        next_cycle();
        DMem_ack = 1'b1;
        @(negedge clk);
        chk("ov_release", 32'(outv), 32'(NONE));
        next_cycle();
        MEM_Access_EN = 1'b0;
        DMem_ack = 1'b0;
        @(negedge clk);
        chk("ov_next_op_start", 32'(outv), 32'(MDS));
        next_cycle();
        pulse_reset();

        // Memory timeout: error on the 64th consecutive wait cycle, sticky afterwards.
        MEM_Access_EN = 1'b1;
        for (int c = 0; c < 63; c++) next_cycle();
        chk("to_before", 32'(Mem_Timeout_err), 0);
        next_cycle();
        chk("to_set", 32'(Mem_Timeout_err), 1);
        chk("to_stall_count", Stall_count, 64);
        DMem_ack = 1'b1;
        next_cycle();
        next_cycle();
        chk("to_sticky", 32'(Mem_Timeout_err), 1);
        pulse_reset();
        chk("to_cleared", 32'(Mem_Timeout_err), 0);

        // Reset while busy, then a fresh single start.
        EX_Is_MulDiv = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_busy_wait", 32'(outv), 32'(MDW));
        reset = 1'b1;
        #1;
        chk("rst_no_start", 32'(outv), 32'(MDW));
        EX_Is_MulDiv = 1'b0;
        #1;
        chk("rst_outputs", 32'(outv), 32'(NONE));
        chk("rst_count", Stall_count, 0);
        EX_Is_MulDiv = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_fresh_start", 32'(outv), 32'(MDS));
        next_cycle();
        chk("rst_single_start", 32'(outv), 32'(MDW));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Stall/flush controller for the 5-stage pipeline; the counterpart to operand forwarding, which resolves RAW hazards by bypass.
- Handles the hazards forwarding cannot hide:
  - load-use bubble;
  - multi-cycle mul/div occupancy in EX, with a one-shot start handshake;
  - data-memory wait;
  - taken-branch flush.
- Drives stall/flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Keeps a stall-cycle counter and a memory-timeout flag.

Parameters:
- RegAddrWidth, 5, register address width.
- CountWidth, 32, width of Stall_count.
- MemTimeout, 64, consecutive memory-wait cycles that set Mem_Timeout_err.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- ID_RS1, ID_RS2  in  RegAddrWidth  source registers of the instruction in ID.
- ID_RS1_used, ID_RS2_used  in  1  source actually read by ID instruction.
- EX_RD  in  RegAddrWidth  destination register in EX.
- EX_Reg_File_EN  in  1  EX instruction writes the register file.
- EX_Mem_Read_EN  in  1  EX instruction is a load.
- EX_Is_MulDiv  in  1  EX holds a mul/div instruction (level).
- EX_Branch_Taken  in  1  branch/jump in EX resolved taken.
- MulDiv_done  in  1  mul/div result valid (1-cycle pulse).
- MEM_Access_EN  in  1  load/store present in MEM.
- DMem_ack  in  1  data memory completes the access this cycle.
- MulDiv_start  out  1  one-cycle start pulse to the mul/div unit.
- PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall  out  1  hold the register.
- IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush  out  1  load a bubble.
- Stall_count  out  CountWidth  saturating count of cycles with PC_stall=1.
- Mem_Timeout_err  out  1  sticky timeout flag.

Behaviour:
- **Output timing.** Control outputs are combinational from registered state plus current inputs, so they take effect in the same cycle.
- **Registered state:**
  - md_state {MD_IDLE, MD_BUSY};
  - md_done_held;
  - mem_wait_cnt;
  - Stall_count;
  - Mem_Timeout_err.
- **Reset.** All registered state is cleared: md_state=MD_IDLE, counters 0, flags 0. With zero inputs, every output is 0. Reset mid-operation abandons any in-flight mul/div; no MulDiv_start is issued while reset is high.
- **Derived terms:**
  - mem_stall = MEM_Access_EN & ~DMem_ack.
  - load_use = EX_Mem_Read_EN & EX_Reg_File_EN & (EX_RD!=0) & ((ID_RS1_used & ID_RS1==EX_RD) | (ID_RS2_used & ID_RS2==EX_RD)).
  - md_wait = (md_state==MD_IDLE & EX_Is_MulDiv) | (md_state==MD_BUSY & ~(MulDiv_done | md_done_held)).
- **Priority per cycle** (first match wins, all other outputs 0):
  1. mem_stall: PC, IF_ID, ID_EX, EX_MEM stall; MEM_WB_flush.
  2. md_wait: PC, IF_ID, ID_EX stall; EX_MEM_flush.
  3. EX_Branch_Taken: IF_ID_flush, ID_EX_flush. The flush overrides any load-use.
  4. load_use: PC_stall, IF_ID_stall, ID_EX_flush (exactly one bubble).
- **Mul/div FSM:**
  - MD_IDLE -> MD_BUSY when EX_Is_MulDiv & ~mem_stall. MulDiv_start=1 in that cycle only.
  - While mem_stall=1, the start is deferred: no pulse, stay in MD_IDLE.
  - In MD_BUSY, if MulDiv_done arrives while mem_stall=1, set md_done_held; the result register is frozen by EX_MEM_stall.
  - MD_BUSY -> MD_IDLE in the first cycle with (MulDiv_done | md_done_held) & ~mem_stall. EX_MEM captures the result that cycle; md_done_held is cleared.
  - Exactly one MulDiv_start per mul/div instruction. MulDiv_done in MD_IDLE is ignored.
- **Memory-wait counter.**
  - mem_wait_cnt increments on each mem_stall cycle and clears when mem_stall=0; it saturates.
  - When it reaches MemTimeout, Mem_Timeout_err is set and stays set until reset.
- **Stall_count** increments when PC_stall=1 and saturates at all-ones.

Decomposition:
- Package hazard_pkg holds:
  - the md_state_t enum;
  - the RegAddrWidth/CountWidth defaults;
  - the stall-vector struct {pc, if_id, id_ex, ex_mem} with a matching flush struct.
- One sub-module, sat_counter (parameterised width, inc, clr, count). It is instantiated for Stall_count and for mem_wait_cnt.

Test Plan:
1. Load-use: EX load x5 with EX_Reg_File_EN=1; ID reads x5 on RS2 -> one cycle of PC_stall=1, IF_ID_stall=1, ID_EX_flush=1. The same case with EX_RD=0 -> no stall.
2. Mul/div: EX_Is_MulDiv held, MulDiv_done pulses 4 cycles after start -> MulDiv_start high exactly 1 cycle, stall+EX_MEM_flush for 4 cycles, release on the done cycle, Stall_count=4.
3. Overlap: mem_stall for 3 cycles, with MulDiv_done arriving in the 2nd -> EX_MEM_stall over all 3, md_done_held set, release on the cycle mem_stall drops, no second start pulse.
4. Branch vs load-use: EX_Branch_Taken=1 and load_use=1 together -> IF_ID_flush=1, ID_EX_flush=1, PC_stall=0.
5. Timeout: MEM_Access_EN=1 and DMem_ack=0 for 64 cycles -> Mem_Timeout_err=1 from cycle 64, still 1 after ack; it clears only on reset.
6. Reset in MD_BUSY -> state MD_IDLE, all outputs 0, counters 0. EX_Is_MulDiv still high after reset deasserts -> a fresh single MulDiv_start.
